// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the RISC-V front end.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// In-order synchronous FIFO with flush; the head is read directly from the storage registers.
module fetch_queue_fifo
   import riscv_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   output entry_t        head,
   output logic [CW-1:0] count
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Storage has no reset; occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction-fetch front end: credit-limited sequential fetch, in-order response
// queue toward IF/ID, and redirect handling that drops responses still in flight.
module fetch_prefetch_queue
   import riscv_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus_4,
   output logic [31:0] out_instr
);

   localparam int QCW = $clog2(DEPTH + 1);
   localparam int OW  = $clog2(MAX_OUTST + 1);

   logic [31:0]    fetch_pc;
   logic [OW-1:0]  discard;
   logic [OW-1:0]  outst;
   logic [OW-1:0]  tag_count;
   logic [QCW-1:0] q_count;
   logic [31:0]    tag_head_pc;
   fetch_entry_t   q_push_data;
   fetch_entry_t   q_head;
   logic           grant;
   logic           rsp_keep;
   logic           q_push;
   logic           q_pop;
   logic           redirect_pc_unused;

   // Outstanding requests are either tagged (will be kept) or marked for discard.
   assign outst = tag_count + discard;

   assign imem_req  = !rst && !redirect
                      && ((32'(q_count) + 32'(outst)) < 32'(DEPTH))
                      && (32'(outst) < 32'(MAX_OUTST));
   assign imem_addr = fetch_pc;
   assign grant     = imem_req && imem_gnt;

   assign rsp_keep    = imem_rvalid && (discard == '0);
   assign q_push      = rsp_keep && !redirect;
   assign q_pop       = out_valid && out_ready && !redirect;
   assign q_push_data = '{pc: tag_head_pc, instr: imem_rdata};

   // Fetch addresses are always word aligned, so the low target bits carry no information.
   assign redirect_pc_unused = ^redirect_pc[1:0];

   fetch_queue_fifo #(
      .DEPTH   (MAX_OUTST),
      .entry_t (logic [31:0])
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect),
      .push      (grant),
      .push_data (fetch_pc),
      .pop       (rsp_keep),
      .head      (tag_head_pc),
      .count     (tag_count)
   );

   fetch_queue_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count)
   );

   // On redirect every request still in flight must be dropped, minus one returning right now.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         discard  <= outst - OW'(imem_rvalid);
      end else begin
         if (grant) fetch_pc <= fetch_pc + 32'd4;
         if (imem_rvalid && (discard != '0)) discard <= discard - OW'(1);
      end
   end

   assign out_valid     = (q_count != '0);
   assign out_pc        = out_valid ? q_head.pc : 32'h0;
   assign out_instr     = out_valid ? q_head.instr : NOP_INSTR;
   assign out_pc_plus_4 = out_pc + 32'd4;

   assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outst != '0));

endmodule
